// File: rtl/sonar_scan_scheduler.sv
// Round-robin N-channel HC-SR04 ranging engine: one FSM triggers each enabled
// sensor in turn, converts echo width to centimetres and publishes per-channel results.
module sonar_scan_scheduler #(
    parameter int NUM_CH         = 3,
    parameter int DIST_W         = 12,
    parameter int TRIG_CYCLES    = 500,
    parameter int CYCLES_PER_CM  = 2900,
    parameter int MAX_CM         = 400,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int GUARD_CYCLES   = 750000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH-1:0]        echo,
    output logic [NUM_CH-1:0]        trig,
    output logic [NUM_CH*DIST_W-1:0] dist_flat,
    output logic [NUM_CH-1:0]        dist_valid,
    output logic [NUM_CH-1:0]        out_of_range,
    output logic                     sample_strobe,
    output logic [3:0]               sample_ch,
    output logic                     busy
);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GUARD} state_t;

    state_t              state_reg, state_next;
    logic [NUM_CH-1:0]   echo_meta_reg, echo_sync_reg;
    logic [3:0]          sel_reg, sel_next;
    logic [3:0]          ptr_reg, ptr_next;
    logic [31:0]         cnt_reg, cnt_next;
    logic [31:0]         presc_reg, presc_next;
    logic [31:0]         high_reg, high_next;
    logic [DIST_W-1:0]   cm_reg, cm_next;
    logic                commit_ok, commit_oor;
    logic                trig_en;
    logic [NUM_CH-1:0]   sel_onehot;
    logic                echo_sel;
    logic [3:0]          ptr_wrap;
    logic [4:0]          pick_idle, pick_guard;
    logic [31:0]         presc_base, high_base, presc_step, high_step;
    logic [DIST_W-1:0]   cm_base, cm_step;
    logic                saturating;

    // Returns {found, index} of the first set mask bit at or after start, wrapping.
    function automatic logic [4:0] pick(input logic [NUM_CH-1:0] m, input logic [3:0] start);
        logic [4:0]        r;
        logic [NUM_CH-1:0] t;
        int                c;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            c = (int'(start) + i) % NUM_CH;
            t = m >> c;
            if (t[0]) r = {1'b1, 4'(c)};
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_meta_reg <= '0;
            echo_sync_reg <= '0;
        end else begin
            echo_meta_reg <= echo;
            echo_sync_reg <= echo_meta_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sel
            assign sel_onehot[gi] = (sel_reg == 4'(gi));
            assign trig[gi]       = trig_en & sel_onehot[gi];
        end
    endgenerate

    assign echo_sel   = |(echo_sync_reg & sel_onehot);
    assign ptr_wrap   = (sel_reg == 4'(NUM_CH - 1)) ? 4'd0 : sel_reg + 4'd1;
    assign pick_idle  = pick(ch_mask, ptr_reg);
    assign pick_guard = pick(ch_mask, ptr_wrap);

    // One echo-high clock of measurement; the rise-detect cycle starts from zero.
    always_comb begin
        presc_base = (state_reg == MEASURE) ? presc_reg : '0;
        high_base  = (state_reg == MEASURE) ? high_reg  : '0;
        cm_base    = (state_reg == MEASURE) ? cm_reg    : '0;
        high_step  = high_base + 32'd1;
        if (presc_base == 32'(CYCLES_PER_CM - 1)) begin
            presc_step = '0;
            cm_step    = cm_base + 1'b1;
        end else begin
            presc_step = presc_base + 32'd1;
            cm_step    = cm_base;
        end
        saturating = (cm_step == DIST_W'(MAX_CM)) || (high_step == 32'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            presc_reg <= '0;
            high_reg  <= '0;
            cm_reg    <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            presc_reg <= presc_next;
            high_reg  <= high_next;
            cm_reg    <= cm_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        presc_next = presc_reg;
        high_next  = high_reg;
        cm_next    = cm_reg;
        commit_ok  = 1'b0;
        commit_oor = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable && pick_idle[4]) begin
                    sel_next   = pick_idle[3:0];
                    cnt_next   = '0;
                    state_next = TRIG;
                end
            end
            TRIG: begin
                if (cnt_reg == 32'(TRIG_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = WAIT_RISE;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            WAIT_RISE, MEASURE: begin
                if (echo_sel) begin
                    presc_next = presc_step;
                    high_next  = high_step;
                    cm_next    = cm_step;
                    if (saturating) begin
                        commit_oor = 1'b1;
                        cnt_next   = '0;
                        state_next = GUARD;
                    end else begin
                        state_next = MEASURE;
                    end
                end else if (state_reg == MEASURE) begin
                    commit_ok  = 1'b1;
                    cnt_next   = '0;
                    state_next = GUARD;
                end else if (cnt_reg == 32'(TIMEOUT_CYCLES - 1)) begin
                    commit_oor = 1'b1;
                    cnt_next   = '0;
                    state_next = GUARD;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            GUARD: begin
                if (cnt_reg == 32'(GUARD_CYCLES - 1)) begin
                    ptr_next = ptr_wrap;
                    cnt_next = '0;
                    if (enable && pick_guard[4]) begin
                        sel_next   = pick_guard[3:0];
                        state_next = TRIG;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        trig_en = (state_reg == TRIG);
        busy    = (state_reg != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_strobe <= 1'b0;
            sample_ch     <= '0;
        end else begin
            sample_strobe <= commit_ok | commit_oor;
            if (commit_ok | commit_oor) sample_ch <= sel_reg;
        end
    end

    // Per-channel result registers; only the selected channel ever updates.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_res
            logic [DIST_W-1:0] dist_reg;
            logic              valid_reg, oor_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dist_reg  <= '0;
                    valid_reg <= 1'b0;
                    oor_reg   <= 1'b0;
                end else if (sel_onehot[gi]) begin
                    if (commit_ok) begin
                        dist_reg  <= cm_reg;
                        valid_reg <= 1'b1;
                        oor_reg   <= 1'b0;
                    end else if (commit_oor) begin
                        dist_reg <= DIST_W'(MAX_CM);
                        oor_reg  <= 1'b1;
                    end
                end
            end
            assign dist_flat[gi*DIST_W +: DIST_W] = dist_reg;
            assign dist_valid[gi]                 = valid_reg;
            assign out_of_range[gi]               = oor_reg;
        end
    endgenerate

endmodule
